reg_bus_router: RTL and testbench

- Parametrised register-interface router for the peripheral bus.
- Takes one reg_req_t master, decodes the address against a runtime rule map and forwards the request to one of NumSlaves reg ports.
- Features the plain demux lacks:
  - decode-error responder (no default-slave aliasing);
  - per-transaction timeout with error completion;
  - optional request cut;
  - saturating error counter.
- Sits between the AXI-to-reg converter and the peripheral register files.

---
 rtl/core_v_mcu_pkg.sv | 56 +++++
 rtl/reg_router_decode.sv | 37 +++
 rtl/reg_bus_router.sv | 186 ++++++++++++++++++
 tb/tb_reg_bus_router.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_v_mcu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_v_mcu_pkg
// Description : Shared peripheral-bus register-interface types, the default
//               address map and router defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package core_v_mcu_pkg;

    localparam int unsigned RegAddrWidth     = 32;
    localparam int unsigned RegDataWidth     = 32;
    localparam int unsigned NumRegSlaves     = 4;
    localparam int unsigned NumRegRules      = 4;
    localparam int unsigned RegTimeoutCycles = 1024;
    localparam logic [RegDataWidth-1:0] RegErrData = 32'hBADC_AB1E;

    // Address rule: idx selects the output port, end_addr is exclusive.
    typedef struct packed {
        logic [31:0]             idx;
        logic [RegAddrWidth-1:0] start_addr;
        logic [RegAddrWidth-1:0] end_addr;
    } rule_t;

    typedef struct packed {
        logic [RegAddrWidth-1:0]   addr;
        logic                      write;
        logic [RegDataWidth-1:0]   wdata;
        logic [RegDataWidth/8-1:0] wstrb;
        logic                      valid;
    } reg_req_t;

    typedef struct packed {
        logic [RegDataWidth-1:0] rdata;
        logic                    error;
        logic                    ready;
    } reg_rsp_t;

    // Default peripheral map: four 4 KiB windows, one per slave.
    localparam rule_t [NumRegRules-1:0] RegMap = '{
        '{idx: 32'd3, start_addr: 32'h0000_3000, end_addr: 32'h0000_4000},
        '{idx: 32'd2, start_addr: 32'h0000_2000, end_addr: 32'h0000_3000},
        '{idx: 32'd1, start_addr: 32'h0000_1000, end_addr: 32'h0000_2000},
        '{idx: 32'd0, start_addr: 32'h0000_0000, end_addr: 32'h0000_1000}
    };

    // Builds the completion returned to the master on any router-generated error.
    function automatic reg_rsp_t err_rsp(input logic [RegDataWidth-1:0] data);
        reg_rsp_t rsp;
        rsp.rdata = data;
        rsp.error = 1'b1;
        rsp.ready = 1'b1;
        return rsp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_router_decode.sv
`default_nettype none
// ============================================================================
// Module      : reg_router_decode
// Description : Combinational first-match address decoder. Rules pointing at
//               a non-existent port are ignored so they cannot alias a slave.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_router_decode
    import core_v_mcu_pkg::*;
#(
    parameter int unsigned NUM_RULES  = 4,
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    input  rule_t [NUM_RULES-1:0]  i_addr_map,
    output logic [SEL_WIDTH-1:0]   o_idx,
    output logic                   o_hit
);

    // Scan from the highest rule down so the lowest matching index is the last writer.
    always_comb begin
        o_idx = '0;
        o_hit = 1'b0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if ((i_addr >= i_addr_map[i].start_addr[ADDR_WIDTH-1:0]) &&
                (i_addr <  i_addr_map[i].end_addr[ADDR_WIDTH-1:0]) &&
                (i_addr_map[i].idx < 32'(NUM_SLAVES))) begin
                o_idx = i_addr_map[i].idx[SEL_WIDTH-1:0];
                o_hit = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_bus_router.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_router
// Description : Register-interface router: decodes one master onto
//               NUM_SLAVES ports with a decode-error responder, per-transaction
//               timeout, optional request cut and a saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bus_router
    import core_v_mcu_pkg::*;
#(
    parameter int unsigned           NUM_SLAVES     = NumRegSlaves,
    parameter int unsigned           NUM_RULES      = NumRegRules,
    parameter int unsigned           ADDR_WIDTH     = RegAddrWidth,
    parameter int unsigned           DATA_WIDTH     = RegDataWidth,
    parameter int unsigned           TIMEOUT_CYCLES = RegTimeoutCycles,
    parameter bit                    CUT_REQ        = 1'b1,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = RegErrData
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  rule_t    [NUM_RULES-1:0]    addr_map_i,
    input  reg_req_t                    in_req_i,
    output reg_rsp_t                    in_rsp_o,
    output reg_req_t [NUM_SLAVES-1:0]   out_req_o,
    input  reg_rsp_t [NUM_SLAVES-1:0]   out_rsp_i,
    input  logic                        clr_cnt_i,
    output logic                        busy_o,
    output logic                        dec_err_o,
    output logic                        tmo_err_o,
    output logic [15:0]                 err_cnt_o
);

    localparam int unsigned c_SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          c_TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST =
        c_CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_FWD  = 2'd1;
    localparam logic [1:0] c_ST_ERR  = 2'd2;

    logic [1:0]         r_state;
    logic [c_SEL_W-1:0] r_sel;
    logic [c_CNT_W-1:0] r_tmo_cnt;
    logic [15:0]        r_err_cnt;

    reg_req_t           w_fwd_req;
    logic [c_SEL_W-1:0] w_dec_idx;
    logic               w_dec_hit;
    logic               w_idle_rdy;
    logic               w_fwd_rdy;
    logic               w_tmo_hit;
    logic               w_dec_err;
    logic               w_tmo_err;

    reg_router_decode #(
        .NUM_RULES  (NUM_RULES),
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SEL_WIDTH  (c_SEL_W)
    ) u_decode (
        .i_addr     (in_req_i.addr[ADDR_WIDTH-1:0]),
        .i_addr_map (addr_map_i),
        .o_idx      (w_dec_idx),
        .o_hit      (w_dec_hit)
    );

    generate
        if (CUT_REQ) begin : g_cut_req
            reg_req_t r_req;

            // Hold a registered copy of the accepted request for the slave side.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_req <= '0;
                end else if ((r_state == c_ST_IDLE) && in_req_i.valid && w_dec_hit) begin
                    r_req <= in_req_i;
                end
            end

            assign w_fwd_req = r_req;
        end else begin : g_pass_req
            assign w_fwd_req = in_req_i;
        end
    endgenerate

    assign w_idle_rdy = out_rsp_i[w_dec_idx].ready;
    assign w_fwd_rdy  = out_rsp_i[r_sel].ready;
    // A slave answer in the last allowed cycle takes precedence over the timeout.
    assign w_tmo_hit  = c_TMO_EN && (r_tmo_cnt == c_TMO_LAST);

    // Route the request to the selected port and steer the matching response back.
    always_comb begin
        out_req_o = '0;
        in_rsp_o  = '0;
        w_dec_err = 1'b0;
        w_tmo_err = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // Zero-latency pass-through; gated by reset so outputs stay quiet while held.
                if (!CUT_REQ && rst_ni && in_req_i.valid && w_dec_hit) begin
                    out_req_o[w_dec_idx] = in_req_i;
                    if (w_idle_rdy) begin
                        in_rsp_o = out_rsp_i[w_dec_idx];
                    end
                end
            end
            c_ST_FWD: begin
                if (w_fwd_rdy) begin
                    out_req_o[r_sel]       = w_fwd_req;
                    out_req_o[r_sel].valid = 1'b1;
                    in_rsp_o               = out_rsp_i[r_sel];
                end else if (w_tmo_hit) begin
                    in_rsp_o  = err_rsp(ERR_DATA);
                    w_tmo_err = 1'b1;
                end else begin
                    out_req_o[r_sel]       = w_fwd_req;
                    out_req_o[r_sel].valid = 1'b1;
                end
            end
            c_ST_ERR: begin
                in_rsp_o  = err_rsp(ERR_DATA);
                w_dec_err = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Transaction FSM: selects the slave, tracks the stall budget, returns to idle on completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= c_ST_IDLE;
            r_sel     <= '0;
            r_tmo_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_tmo_cnt <= '0;
                    if (in_req_i.valid) begin
                        r_sel <= w_dec_idx;
                        if (!w_dec_hit) begin
                            r_state <= c_ST_ERR;
                        end else if (CUT_REQ || !w_idle_rdy) begin
                            r_state <= c_ST_FWD;
                        end
                    end
                end
                c_ST_FWD: begin
                    if (w_fwd_rdy || w_tmo_hit) begin
                        r_state   <= c_ST_IDLE;
                        r_tmo_cnt <= '0;
                    end else if (c_TMO_EN) begin
                        r_tmo_cnt <= r_tmo_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_ERR: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of error completions; a clear wins over a coincident error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_cnt <= '0;
        end else if (clr_cnt_i) begin
            r_err_cnt <= '0;
        end else if ((w_dec_err || w_tmo_err) && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign busy_o    = (r_state != c_ST_IDLE);
    assign dec_err_o = w_dec_err;
    assign tmo_err_o = w_tmo_err;
    assign err_cnt_o = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bus_router
// Description : Directed self-checking bench for reg_bus_router; one instance
//               with the request cut, one with combinational forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bus_router;
    import core_v_mcu_pkg::*;

    logic clk;
    logic rst_n;

    rule_t    [3:0] addr_map;
    reg_req_t       req_c, req_n;
    reg_rsp_t       rsp_c, rsp_n;
    reg_req_t [3:0] oreq_c, oreq_n;
    reg_rsp_t [3:0] srsp_c, srsp_n;
    logic           clr_c, clr_n;
    logic           busy_c, busy_n;
    logic           dec_c, dec_n;
    logic           tmo_c, tmo_n;
    logic [15:0]    cnt_c, cnt_n;

    int n_total;
    int n_bad;

    assign addr_map = RegMap;

    reg_bus_router #(
        .NUM_SLAVES(4), .NUM_RULES(4), .TIMEOUT_CYCLES(8), .CUT_REQ(1'b1)
    ) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .addr_map_i(addr_map),
        .in_req_i(req_c), .in_rsp_o(rsp_c),
        .out_req_o(oreq_c), .out_rsp_i(srsp_c),
        .clr_cnt_i(clr_c), .busy_o(busy_c), .dec_err_o(dec_c),
        .tmo_err_o(tmo_c), .err_cnt_o(cnt_c)
    );

    reg_bus_router #(
        .NUM_SLAVES(4), .NUM_RULES(4), .TIMEOUT_CYCLES(8), .CUT_REQ(1'b0)
    ) dut_n (
        .clk_i(clk), .rst_ni(rst_n), .addr_map_i(addr_map),
        .in_req_i(req_n), .in_rsp_o(rsp_n),
        .out_req_o(oreq_n), .out_rsp_i(srsp_n),
        .clr_cnt_i(clr_n), .busy_o(busy_n), .dec_err_o(dec_n),
        .tmo_err_o(tmo_n), .err_cnt_o(cnt_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] valids(input reg_req_t [3:0] r);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = r[i].valid;
        return v;
    endfunction

    function automatic reg_req_t mkreq(input logic [31:0] a, input logic w,
                                       input logic [31:0] d, input logic [3:0] s);
        reg_req_t q;
        q.addr  = a;
        q.write = w;
        q.wdata = d;
        q.wstrb = s;
        q.valid = 1'b1;
        return q;
    endfunction

    // One decode-error transaction on the cut instance, optionally clearing the counter in its error cycle.
    task automatic miss_c(input logic clr);
        @(negedge clk);
        req_c = mkreq(32'h0000_9000, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        clr_c = clr;
        @(posedge clk);
        #1;
        req_c.valid = 1'b0;
        clr_c       = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        req_c = '0; req_n = '0; srsp_c = '0; srsp_n = '0;
        clr_c = 1'b0; clr_n = 1'b0;
        n_total = 0; n_bad = 0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy_c, 0);
        chk("rst_rsp", rsp_c, 0);
        chk("rst_outv", valids(oreq_c), 0);
        chk("rst_cnt", cnt_c, 0);
        chk("rst_outv_n", valids(oreq_n), 0);
        rst_n = 1'b1;

        // Cut read to slave2, slave answers in its first valid cycle
        @(negedge clk);
        req_c = mkreq(32'h0000_2004, 1'b0, 32'h0, 4'h0);
        srsp_c[2] = '{rdata: 32'h1234, error: 1'b0, ready: 1'b1};
        #1;
        chk("t1_cap_rdy", rsp_c.ready, 0);
        chk("t1_cap_outv", valids(oreq_c), 4'b0000);
        @(negedge clk);
        #1;
        chk("t1_outv", valids(oreq_c), 4'b0100);
        chk("t1_addr", oreq_c[2].addr, 32'h2004);
        chk("t1_rdy", rsp_c.ready, 1);
        chk("t1_rdata", rsp_c.rdata, 32'h1234);
        chk("t1_err", rsp_c.error, 0);
        chk("t1_busy", busy_c, 1);
        @(posedge clk);
        #1;
        req_c.valid = 1'b0;
        srsp_c[2]   = '0;
        @(negedge clk);
        #1;
        chk("t1_idle", busy_c, 0);

        // Unmapped read -> decode error one cycle after valid
        @(negedge clk);
        req_c = mkreq(32'h0000_9000, 1'b0, 32'h0, 4'h0);
        #1;
        chk("t2_wait_rdy", rsp_c.ready, 0);
        chk("t2_wait_outv", valids(oreq_c), 0);
        @(negedge clk);
        #1;
        chk("t2_rdy", rsp_c.ready, 1);
        chk("t2_err", rsp_c.error, 1);
        chk("t2_rdata", rsp_c.rdata, 32'hBADC_AB1E);
        chk("t2_dec", dec_c, 1);
        chk("t2_outv", valids(oreq_c), 0);
        @(posedge clk);
        #1;
        req_c.valid = 1'b0;
        @(negedge clk);
        #1;
        chk("t2_dec_off", dec_c, 0);
        chk("t2_cnt", cnt_c, 1);
        chk("t2_busy", busy_c, 0);

        // Timeout: slave1 never ready, error completion in the 8th forward cycle
        @(negedge clk);
        req_c = mkreq(32'h0000_1010, 1'b0, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (i < 7) begin
                chk("t3_outv", valids(oreq_c), 4'b0010);
                chk("t3_rdy", rsp_c.ready, 0);
            end else begin
                chk("t3_outv_drop", valids(oreq_c), 4'b0000);
                chk("t3_rdy", rsp_c.ready, 1);
                chk("t3_err", rsp_c.error, 1);
                chk("t3_rdata", rsp_c.rdata, 32'hBADC_AB1E);
                chk("t3_tmo", tmo_c, 1);
            end
        end
        @(posedge clk);
        #1;
        req_c.valid = 1'b0;
        @(negedge clk);
        srsp_c[1] = '{rdata: 32'h5555, error: 1'b0, ready: 1'b1};
        #1;
        chk("t3_late_rdy", rsp_c.ready, 0);
        chk("t3_late_tmo", tmo_c, 0);
        chk("t3_late_busy", busy_c, 0);
        chk("t3_cnt", cnt_c, 2);
        srsp_c[1] = '0;

        // Slave ready exactly in the last allowed cycle -> normal completion
        @(negedge clk);
        req_c = mkreq(32'h0000_1020, 1'b0, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 7) srsp_c[1] = '{rdata: 32'hCAFE, error: 1'b0, ready: 1'b1};
            #1;
            if (i < 7) begin
                chk("t4_rdy", rsp_c.ready, 0);
            end else begin
                chk("t4_outv", valids(oreq_c), 4'b0010);
                chk("t4_rdy", rsp_c.ready, 1);
                chk("t4_err", rsp_c.error, 0);
                chk("t4_rdata", rsp_c.rdata, 32'hCAFE);
                chk("t4_tmo", tmo_c, 0);
            end
        end
        @(posedge clk);
        #1;
        req_c.valid = 1'b0;
        srsp_c[1]   = '0;
        @(negedge clk);
        #1;
        chk("t4_busy", busy_c, 0);
        chk("t4_cnt", cnt_c, 2);

        // Combinational forward: write to slave0, completes in the same cycle
        srsp_n[0] = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
        req_n = mkreq(32'h0000_0008, 1'b1, 32'hDEAD_BEEF, 4'hF);
        #1;
        chk("t5_rdy", rsp_n.ready, 1);
        chk("t5_err", rsp_n.error, 0);
        chk("t5_outv", valids(oreq_n), 4'b0001);
        chk("t5_wdata", oreq_n[0].wdata, 32'hDEAD_BEEF);
        chk("t5_wstrb", oreq_n[0].wstrb, 4'hF);
        chk("t5_write", oreq_n[0].write, 1);
        chk("t5_busy", busy_n, 0);
        @(posedge clk);
        #1;
        chk("t5_busy_after", busy_n, 0);
        req_n.valid = 1'b0;

        // Boundaries: 0x1000 belongs to slave1, 0x0FFC to slave0
        @(negedge clk);
        srsp_n[1] = '{rdata: 32'h77, error: 1'b0, ready: 1'b1};
        req_n = mkreq(32'h0000_1000, 1'b0, 32'h0, 4'h0);
        #1;
        chk("t5b_outv", valids(oreq_n), 4'b0010);
        chk("t5b_rdata", rsp_n.rdata, 32'h77);
        req_n = mkreq(32'h0000_0FFC, 1'b0, 32'h0, 4'h0);
        #1;
        chk("t5c_outv", valids(oreq_n), 4'b0001);
        chk("t5c_rdy", rsp_n.ready, 1);
        @(posedge clk);
        #1;
        req_n.valid = 1'b0;
        srsp_n      = '0;

        // Counter saturation and clear priority
        @(negedge clk);
        force dut_c.r_err_cnt = 16'hFFFE;
        #1;
        release dut_c.r_err_cnt;
        #1;
        chk("t6_preload", cnt_c, 16'hFFFE);
        miss_c(1'b0);
        chk("t6_to_max", cnt_c, 16'hFFFF);
        miss_c(1'b0);
        chk("t6_sat", cnt_c, 16'hFFFF);
        miss_c(1'b1);
        chk("t6_clr", cnt_c, 16'h0000);

        // Reset asserted while forwarding
        @(negedge clk);
        req_c = mkreq(32'h0000_3004, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        #1;
        chk("t7_fwd_outv", valids(oreq_c), 4'b1000);
        chk("t7_fwd_busy", busy_c, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_outv", valids(oreq_c), 0);
        chk("t7_rst_rsp", rsp_c, 0);
        chk("t7_rst_busy", busy_c, 0);
        req_c.valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("t7_post_busy", busy_c, 0);
        chk("t7_post_outv", valids(oreq_c), 0);
        chk("t7_post_rdy", rsp_c.ready, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
